// File: rtl/ckpt_register_file_pkg.sv
// Shared default geometry for ckpt_register_file and its checkpoint store.
package ckpt_register_file_pkg;

   localparam int unsigned DEF_ISSUE_WIDTH = 2;
   localparam int unsigned DEF_ROB_IDX_LEN = 4;
   localparam int unsigned DEF_NUM_REGS    = 32;
   localparam int unsigned DEF_NUM_CKPTS   = 4;
   localparam int unsigned DEF_XLEN        = 32;

endpackage

// File: rtl/ckpt_register_file_store.sv
// Circular store of rename-map checkpoints (rf_ckpt_store): slot array,
// head/tail/count pointers, and commit-clear of CB bits held in every slot.
module ckpt_register_file_store
   import ckpt_register_file_pkg::*;
#(
   parameter int unsigned ISSUE_WIDTH = DEF_ISSUE_WIDTH,
   parameter int unsigned ROB_IDX_LEN = DEF_ROB_IDX_LEN,
   parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
   parameter int unsigned NUM_CKPTS   = DEF_NUM_CKPTS,
   localparam int unsigned CIDX       = $clog2(NUM_CKPTS),
   localparam int unsigned EW         = ROB_IDX_LEN + 1
)(
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     fls,
   input  logic                                     take_i,
   input  logic                                     release_i,
   input  logic                                     restore_i,
   input  logic [CIDX-1:0]                          restore_tag_i,
   input  logic [NUM_REGS-1:0][EW-1:0]              snap_i,
   input  logic [ISSUE_WIDTH-1:0]                   clr_vld_i,
   input  logic [ISSUE_WIDTH-1:0][ROB_IDX_LEN-1:0]  clr_tag_i,
   output logic [NUM_REGS-1:0][EW-1:0]              restore_map_o,
   output logic [CIDX-1:0]                          tag_o,
   output logic                                     full_o,
   output logic [CIDX:0]                            count_o
);

   typedef struct packed {
      logic                   cb;
      logic [ROB_IDX_LEN-1:0] rob_ref;
   } rf_ckpt_entry_t;
   typedef rf_ckpt_entry_t [NUM_REGS-1:0] ckpt_map_t;

   localparam logic [CIDX:0]   CNT_FULL = (CIDX+1)'(NUM_CKPTS);
   localparam logic [CIDX:0]   CNT_ONE  = (CIDX+1)'(1);
   localparam logic [CIDX-1:0] PTR_ONE  = CIDX'(1);

   ckpt_map_t [NUM_CKPTS-1:0] slots_q, slots_d, slots_clr;
   ckpt_map_t                 snap;
   logic [CIDX-1:0]           head_q, head_d, head_rel, tail_q, tail_d;
   logic [CIDX:0]             count_q, count_d, count_rel;

   assign snap          = snap_i;
   assign tag_o         = tail_q;
   assign count_o       = count_q;
   assign full_o        = (count_q == CNT_FULL);

   always_comb begin
      slots_clr = slots_q;
      for (int unsigned s = 0; s < NUM_CKPTS; s++)
         for (int unsigned r = 0; r < NUM_REGS; r++)
            for (int unsigned l = 0; l < ISSUE_WIDTH; l++)
               if (clr_vld_i[l] && slots_clr[s][r].cb && slots_clr[s][r].rob_ref == clr_tag_i[l])
                  slots_clr[s][r].cb = 1'b0;
   end

   assign restore_map_o = slots_clr[restore_tag_i];

   // Release is applied before restore so the restored count is measured from the new head.
   always_comb begin
      head_rel  = head_q;
      count_rel = count_q;
      if (release_i && count_q != '0) begin
         head_rel  = head_q + PTR_ONE;
         count_rel = count_q - CNT_ONE;
      end
      slots_d = slots_clr;
      head_d  = head_rel;
      tail_d  = tail_q;
      count_d = count_rel;
      if (fls) begin
         for (int unsigned s = 0; s < NUM_CKPTS; s++)
            for (int unsigned r = 0; r < NUM_REGS; r++)
               slots_d[s][r].cb = 1'b0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (restore_i) begin
         tail_d  = restore_tag_i;
         count_d = {1'b0, restore_tag_i - head_rel};
      end else if (take_i && !full_o) begin
         slots_d[tail_q] = snap;
         tail_d          = tail_q + PTR_ONE;
         count_d         = count_rel + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slots_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         slots_q <= slots_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (!fls && release_i) begin
            assert (count_q != '0) else $error("ckpt release with no live checkpoint");
            if (restore_i)
               assert (restore_tag_i != head_q) else $error("ckpt restore of slot released this cycle");
         end
      end
   end

endmodule

// File: rtl/ckpt_register_file.sv
// Architectural register file with rename tags and branch checkpoints.
// Optional same-cycle commit-to-read bypass: define RF_READ_BYPASS_EN.
module ckpt_register_file
   import ckpt_register_file_pkg::*;
#(
   parameter int unsigned ISSUE_WIDTH = DEF_ISSUE_WIDTH,
   parameter int unsigned ROB_IDX_LEN = DEF_ROB_IDX_LEN,
   parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
   parameter int unsigned NUM_CKPTS   = DEF_NUM_CKPTS,
   parameter int unsigned XLEN        = DEF_XLEN,
   localparam int unsigned RIDX       = $clog2(NUM_REGS),
   localparam int unsigned CIDX       = $clog2(NUM_CKPTS),
   localparam int unsigned EW         = ROB_IDX_LEN + 1
)(
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     fls,
   input  logic [ISSUE_WIDTH-1:0]                   speculate_i,
   input  logic [ISSUE_WIDTH-1:0][RIDX-1:0]         speculate_idx_i,
   input  logic [ISSUE_WIDTH-1:0][ROB_IDX_LEN-1:0]  speculate_data_i,
   input  logic [ISSUE_WIDTH-1:0]                   commit_i,
   input  logic [ISSUE_WIDTH-1:0][RIDX-1:0]         commit_idx_i,
   input  logic [ISSUE_WIDTH-1:0][ROB_IDX_LEN-1:0]  commit_rob_idx_i,
   input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]         commit_data_i,
   input  logic [2*ISSUE_WIDTH-1:0][RIDX-1:0]       rd_idx_i,
   output logic [2*ISSUE_WIDTH-1:0]                 rd_cb_o,
   output logic [2*ISSUE_WIDTH-1:0][XLEN-1:0]       rd_val_o,
   input  logic                                     ckpt_take_i,
   output logic [CIDX-1:0]                          ckpt_tag_o,
   input  logic                                     ckpt_release_i,
   input  logic                                     ckpt_restore_i,
   input  logic [CIDX-1:0]                          ckpt_restore_tag_i,
   output logic                                     ckpt_full_o,
   output logic [CIDX:0]                            ckpt_count_o
);

   typedef struct packed {
      logic                   cb;
      logic [ROB_IDX_LEN-1:0] rob_ref;
   } rf_ckpt_entry_t;

   typedef struct packed {
      logic [XLEN-1:0]        data;
      logic                   cb;
      logic [ROB_IDX_LEN-1:0] rob_ref;
   } reg_file_element_t;

   reg_file_element_t [NUM_REGS-1:0] rf_q, rf_d, rf_spec;
   rf_ckpt_entry_t    [NUM_REGS-1:0] snap, restore_map;
   logic [ISSUE_WIDTH-1:0]           commit_vld;

   always_comb begin
      for (int unsigned l = 0; l < ISSUE_WIDTH; l++)
         commit_vld[l] = commit_i[l] && (commit_idx_i[l] != '0);
   end

   // rf_spec is the map after this cycle's commits and speculates; it is also the take snapshot.
   always_comb begin
      rf_spec = rf_q;
      for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
         if (commit_vld[l]) begin
            rf_spec[commit_idx_i[l]].data = commit_data_i[l];
            if (rf_q[commit_idx_i[l]].cb && rf_q[commit_idx_i[l]].rob_ref == commit_rob_idx_i[l])
               rf_spec[commit_idx_i[l]].cb = 1'b0;
         end
      end
      for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
         if (speculate_i[l] && speculate_idx_i[l] != '0) begin
            rf_spec[speculate_idx_i[l]].cb      = 1'b1;
            rf_spec[speculate_idx_i[l]].rob_ref = speculate_data_i[l];
         end
      end
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         snap[r].cb      = rf_spec[r].cb;
         snap[r].rob_ref = rf_spec[r].rob_ref;
      end
   end

   always_comb begin
      rf_d = rf_spec;
      if (fls) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            rf_d[r].cb      = 1'b0;
            rf_d[r].rob_ref = rf_q[r].rob_ref;
         end
      end else if (ckpt_restore_i) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            rf_d[r].cb      = restore_map[r].cb;
            rf_d[r].rob_ref = restore_map[r].rob_ref;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rf_q <= '0;
      else     rf_q <= rf_d;
   end

   always_comb begin
      for (int unsigned p = 0; p < 2*ISSUE_WIDTH; p++) begin
         rd_cb_o[p]  = rf_q[rd_idx_i[p]].cb;
         rd_val_o[p] = rf_q[rd_idx_i[p]].cb ? XLEN'(rf_q[rd_idx_i[p]].rob_ref)
                                            : rf_q[rd_idx_i[p]].data;
`ifdef RF_READ_BYPASS_EN
         for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
            if (rf_q[rd_idx_i[p]].cb && commit_vld[l] &&
                rf_q[rd_idx_i[p]].rob_ref == commit_rob_idx_i[l]) begin
               rd_cb_o[p]  = 1'b0;
               rd_val_o[p] = commit_data_i[l];
            end
         end
`endif
      end
   end

   ckpt_register_file_store #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .ROB_IDX_LEN (ROB_IDX_LEN),
      .NUM_REGS    (NUM_REGS),
      .NUM_CKPTS   (NUM_CKPTS)
   ) u_store (
      .clk           (clk),
      .rst           (rst),
      .fls           (fls),
      .take_i        (ckpt_take_i),
      .release_i     (ckpt_release_i),
      .restore_i     (ckpt_restore_i),
      .restore_tag_i (ckpt_restore_tag_i),
      .snap_i        (snap),
      .clr_vld_i     (commit_vld),
      .clr_tag_i     (commit_rob_idx_i),
      .restore_map_o (restore_map),
      .tag_o         (ckpt_tag_o),
      .full_o        (ckpt_full_o),
      .count_o       (ckpt_count_o)
   );

endmodule

// File: tb/tb_ckpt_register_file.sv
// Directed bench for ckpt_register_file with a queue-based reference model.
`timescale 1ns/1ps
module tb_ckpt_register_file;

   localparam int unsigned IW = 2, RL = 4, NR = 32, NC = 4, XL = 32, RI = 5, CI = 2;

   logic                     clk = 1'b0;
   logic                     rst, fls;
   logic [IW-1:0]            speculate_i;
   logic [IW-1:0][RI-1:0]    speculate_idx_i;
   logic [IW-1:0][RL-1:0]    speculate_data_i;
   logic [IW-1:0]            commit_i;
   logic [IW-1:0][RI-1:0]    commit_idx_i;
   logic [IW-1:0][RL-1:0]    commit_rob_idx_i;
   logic [IW-1:0][XL-1:0]    commit_data_i;
   logic [2*IW-1:0][RI-1:0]  rd_idx_i;
   logic [2*IW-1:0]          rd_cb_o;
   logic [2*IW-1:0][XL-1:0]  rd_val_o;
   logic                     ckpt_take_i, ckpt_release_i, ckpt_restore_i;
   logic [CI-1:0]            ckpt_tag_o, ckpt_restore_tag_i;
   logic                     ckpt_full_o;
   logic [CI:0]              ckpt_count_o;

   ckpt_register_file #(
      .ISSUE_WIDTH (IW), .ROB_IDX_LEN (RL), .NUM_REGS (NR), .NUM_CKPTS (NC), .XLEN (XL)
   ) dut (
      .clk (clk), .rst (rst), .fls (fls),
      .speculate_i (speculate_i), .speculate_idx_i (speculate_idx_i),
      .speculate_data_i (speculate_data_i),
      .commit_i (commit_i), .commit_idx_i (commit_idx_i),
      .commit_rob_idx_i (commit_rob_idx_i), .commit_data_i (commit_data_i),
      .rd_idx_i (rd_idx_i), .rd_cb_o (rd_cb_o), .rd_val_o (rd_val_o),
      .ckpt_take_i (ckpt_take_i), .ckpt_tag_o (ckpt_tag_o),
      .ckpt_release_i (ckpt_release_i), .ckpt_restore_i (ckpt_restore_i),
      .ckpt_restore_tag_i (ckpt_restore_tag_i), .ckpt_full_o (ckpt_full_o),
      .ckpt_count_o (ckpt_count_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   bit armed = 1'b0;

   // Reference model: flat map plus a queue of live snapshots, oldest first.
   logic [XL-1:0]         m_data [NR];
   logic [NR-1:0]         m_cb;
   logic [NR-1:0][RL-1:0] m_rob;
   logic [NR-1:0]         q_cb  [$];
   logic [NR-1:0][RL-1:0] q_rob [$];
   int unsigned           m_head;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int unsigned size0, k, idx;
      logic [NR-1:0] cbv, c;
      logic [NR-1:0][RL-1:0] robv, rv;
      if (rst) begin
         for (int r = 0; r < NR; r++) m_data[r] = '0;
         m_cb = '0; m_rob = '0; q_cb.delete(); q_rob.delete(); m_head = 0;
         return;
      end
      size0 = q_cb.size();
      cbv = m_cb; robv = m_rob;
      for (int l = 0; l < IW; l++) begin
         if (commit_i[l] && commit_idx_i[l] != '0) begin
            idx = commit_idx_i[l];
            m_data[idx] = commit_data_i[l];
            if (m_cb[idx] && m_rob[idx] == commit_rob_idx_i[l]) cbv[idx] = 1'b0;
            for (int s = 0; s < q_cb.size(); s++) begin
               c = q_cb[s]; rv = q_rob[s];
               for (int r = 0; r < NR; r++)
                  if (c[r] && rv[r] == commit_rob_idx_i[l]) c[r] = 1'b0;
               q_cb[s] = c;
            end
         end
      end
      if (fls) begin
         cbv = '0; robv = m_rob;
         q_cb.delete(); q_rob.delete(); m_head = 0;
      end else begin
         if (ckpt_release_i && size0 > 0) begin
            void'(q_cb.pop_front()); void'(q_rob.pop_front());
            m_head = (m_head + 1) % NC;
         end
         if (ckpt_restore_i) begin
            k = (int'(ckpt_restore_tag_i) + NC - m_head) % NC;
            if (k < q_cb.size()) begin
               cbv = q_cb[k]; robv = q_rob[k];
               while (q_cb.size() > k) begin
                  void'(q_cb.pop_back()); void'(q_rob.pop_back());
               end
            end
         end else begin
            for (int l = 0; l < IW; l++)
               if (speculate_i[l] && speculate_idx_i[l] != '0) begin
                  cbv[speculate_idx_i[l]]  = 1'b1;
                  robv[speculate_idx_i[l]] = speculate_data_i[l];
               end
            if (ckpt_take_i && size0 < NC) begin
               q_cb.push_back(cbv); q_rob.push_back(robv);
            end
         end
      end
      m_cb = cbv; m_rob = robv;
   endtask

   task automatic exp_read(input int p, output logic ecb, output logic [XL-1:0] ev);
      int unsigned idx;
      idx = rd_idx_i[p];
      ecb = m_cb[idx];
      ev  = m_cb[idx] ? XL'(m_rob[idx]) : m_data[idx];
`ifdef RF_READ_BYPASS_EN
      for (int l = 0; l < IW; l++)
         if (m_cb[idx] && commit_i[l] && commit_idx_i[l] != '0 && commit_rob_idx_i[l] == m_rob[idx]) begin
            ecb = 1'b0;
            ev  = commit_data_i[l];
         end
`endif
   endtask

   always @(posedge clk) model_step();

   logic          cmp_cb;
   logic [XL-1:0] cmp_val;
   always @(negedge clk) begin
      if (armed) begin
         for (int p = 0; p < 2*IW; p++) begin
            exp_read(p, cmp_cb, cmp_val);
            chk($sformatf("cmp_rd%0d_cb", p), 32'(rd_cb_o[p]), 32'(cmp_cb));
            chk($sformatf("cmp_rd%0d_val", p), rd_val_o[p], cmp_val);
         end
         chk("cmp_ckpt_count", 32'(ckpt_count_o), q_cb.size());
         chk("cmp_ckpt_full", 32'(ckpt_full_o), 32'(q_cb.size() == NC));
         chk("cmp_ckpt_tag", 32'(ckpt_tag_o), (m_head + q_cb.size()) % NC);
      end
   end

   task automatic idle();
      fls = 0; speculate_i = '0; speculate_idx_i = '0; speculate_data_i = '0;
      commit_i = '0; commit_idx_i = '0; commit_rob_idx_i = '0; commit_data_i = '0;
      ckpt_take_i = 0; ckpt_release_i = 0; ckpt_restore_i = 0; ckpt_restore_tag_i = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic spec(input int l, input int idx, input int tag);
      speculate_i[l] = 1'b1; speculate_idx_i[l] = RI'(idx); speculate_data_i[l] = RL'(tag);
   endtask

   task automatic cmt(input int l, input int idx, input int tag, input logic [XL-1:0] d);
      commit_i[l] = 1'b1; commit_idx_i[l] = RI'(idx); commit_rob_idx_i[l] = RL'(tag);
      commit_data_i[l] = d;
   endtask

   task automatic chk_rd(input string name, input int p, input logic ecb, input logic [XL-1:0] ev);
      chk({name, "_cb"}, 32'(rd_cb_o[p]), 32'(ecb));
      chk({name, "_val"}, rd_val_o[p], ev);
   endtask

   task automatic chk_ck(input string name, input int cnt, input int tag, input int full);
      chk({name, "_count"}, 32'(ckpt_count_o), cnt);
      chk({name, "_tag"}, 32'(ckpt_tag_o), tag);
      chk({name, "_full"}, 32'(ckpt_full_o), full);
   endtask

   initial begin
      rst = 1; idle();
      rd_idx_i[0] = 5; rd_idx_i[1] = 7; rd_idx_i[2] = 9; rd_idx_i[3] = 0;
      @(posedge clk); #1; armed = 1;
      @(posedge clk); #1; rst = 0; #1;
      chk_rd("reset_x5", 0, 0, 0);
      chk_ck("reset", 0, 0, 0);

      spec(0, 5, 3); step();
      chk_rd("spec_x5", 0, 1, 3);
      cmt(0, 5, 3, 'hDEAD); step();
      chk_rd("commit_x5", 0, 0, 'hDEAD);
      spec(0, 5, 3); step();
      cmt(0, 5, 2, 'h1234); step();
      chk_rd("stale_commit_x5", 0, 1, 3);
      cmt(0, 5, 3, 'h5678); step();
      chk_rd("late_commit_x5", 0, 0, 'h5678);

      spec(1, 7, 1); ckpt_take_i = 1; step();
      chk_ck("take1", 1, 1, 0);
      spec(0, 7, 4); step();
      chk_rd("respec_x7", 1, 1, 4);
      ckpt_restore_i = 1; ckpt_restore_tag_i = 0; step();
      chk_rd("restore_x7", 1, 1, 1);
      chk_ck("restore", 0, 0, 0);

      spec(0, 7, 1); ckpt_take_i = 1; step();
      spec(0, 7, 4); step();
      cmt(1, 7, 1, 'hC0DE); step();
      chk_rd("old_commit_x7", 1, 1, 4);
      ckpt_restore_i = 1; ckpt_restore_tag_i = 0; step();
      chk_rd("restore_cleared_x7", 1, 0, 'hC0DE);

      for (int i = 0; i < 4; i++) begin
         ckpt_take_i = 1; step();
         chk_ck($sformatf("fill%0d", i), i + 1, (i + 1) % 4, (i == 3) ? 1 : 0);
      end
      ckpt_take_i = 1; step();
      chk_ck("take_full", 4, 0, 1);
      ckpt_take_i = 1; ckpt_release_i = 1; step();
      chk_ck("rel_take_full", 3, 0, 0);
      ckpt_take_i = 1; step();
      chk_ck("take_wrap", 4, 1, 1);
      ckpt_take_i = 1; ckpt_release_i = 1; step();
      ckpt_take_i = 1; ckpt_release_i = 1; step();
      chk_ck("rel_take", 3, 2, 0);
      ckpt_release_i = 1; ckpt_restore_i = 1; ckpt_restore_tag_i = 1; step();
      chk_ck("rel_restore", 1, 1, 0);
      ckpt_release_i = 1; step();
      chk_ck("release_last", 0, 1, 0);

      rd_idx_i[2] = 3; rd_idx_i[3] = 4;
      cmt(0, 3, 0, 'hAAAA); cmt(1, 3, 0, 'hBBBB); spec(0, 4, 2); spec(1, 4, 5); step();
      chk_rd("dual_commit_x3", 2, 0, 'hBBBB);
      chk_rd("dual_spec_x4", 3, 1, 5);
      rd_idx_i[3] = 0;
      spec(0, 0, 7); cmt(0, 0, 7, 1); step();
      chk_rd("x0_zero", 3, 0, 0);
      spec(0, 5, 9); step();
      cmt(0, 5, 9, 'h99); spec(1, 5, 10); step();
      chk_rd("spec_over_commit_x5", 0, 1, 10);

      rd_idx_i[2] = 9;
      ckpt_take_i = 1; step();
      fls = 1; spec(1, 9, 12); ckpt_take_i = 1; step();
      chk_rd("flush_x5", 0, 0, 'h99);
      chk_rd("flush_x9", 2, 0, 0);
      chk_ck("flush", 0, 0, 0);

      spec(0, 9, 6); step();
      cmt(1, 9, 6, 'h55); #1;
`ifdef RF_READ_BYPASS_EN
      chk_rd("bypass_x9", 2, 0, 'h55);
`else
      chk_rd("bypass_x9", 2, 1, 6);
`endif
      step();
      chk_rd("after_commit_x9", 2, 0, 'h55);

      @(posedge clk); @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
